// File: rtl/core_bus_arbiter_pkg.sv
// Shared types for the core bus arbiter: master IDs, FSM states and the request payload.
package core_bus_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  localparam logic ARB_ID_M0 = 1'b0;
  localparam logic ARB_ID_M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOCK_M0 = 2'd1,
    ST_LOCK_M1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [SEL_W-1:0]  sel;
    logic              we;
  } bus_req_t;

endpackage

// File: rtl/core_bus_arbiter_id_fifo.sv
// Outstanding-request ID FIFO (1 bit per entry); the head ID steers responses back in order.
module core_bus_arbiter_id_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned MEM_N = 1 << PTR_W;

  logic [MEM_N-1:0] mem_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_id;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// 2-master to 1-slave bus arbiter: fixed priority dbus (M0) over ibus (M1) with a starvation
// escape for M1, pipelined requests and in-order response routing.
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_OUTST    = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  input  logic [SEL_W-1:0]  m0_sel_i,
  input  logic              m0_we_i,
  input  logic              m0_req_valid_i,
  output logic              m0_req_ready_o,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_rsp_valid_o,
  input  logic              m0_rsp_ready_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  input  logic [SEL_W-1:0]  m1_sel_i,
  input  logic              m1_we_i,
  input  logic              m1_req_valid_i,
  output logic              m1_req_ready_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_rsp_valid_o,
  input  logic              m1_rsp_ready_i,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  output logic [SEL_W-1:0]  s_sel_o,
  output logic              s_we_o,
  output logic              s_req_valid_o,
  input  logic              s_req_ready_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_rsp_valid_i,
  output logic              s_rsp_ready_o
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e          state_q, state_d;
  logic                arb_en_q;
  logic [STARVE_W-1:0] starve_q, starve_d;
  bus_req_t            m0_req, m1_req, win_req;
  logic                win_id, win_valid, force_m1, accept;
  logic                fifo_full, fifo_empty, head_id, rsp_ready_sel, pop;

  assign m0_req   = '{addr: m0_addr_i, data: m0_data_i, sel: m0_sel_i, we: m0_we_i};
  assign m1_req   = '{addr: m1_addr_i, data: m1_data_i, sel: m1_sel_i, we: m1_we_i};
  assign force_m1 = (starve_q == STARVE_W'(STARVE_LIMIT));

  // Grant: a locked state pins the owner, otherwise M0 wins unless M1 is being starved.
  always_comb begin
    win_id = ARB_ID_M0;
    case (state_q)
      ST_LOCK_M0: win_id = ARB_ID_M0;
      ST_LOCK_M1: win_id = ARB_ID_M1;
      default:    win_id = (m1_req_valid_i && (force_m1 || !m0_req_valid_i)) ? ARB_ID_M1 : ARB_ID_M0;
    endcase
  end

  // Grants stay off until the first clock after reset release, keeping all outputs quiet in reset.
  assign win_valid     = arb_en_q & ((win_id == ARB_ID_M1) ? m1_req_valid_i : m0_req_valid_i);
  assign win_req       = (win_id == ARB_ID_M1) ? m1_req : m0_req;
  assign s_req_valid_o = win_valid & ~fifo_full;
  assign accept        = s_req_valid_o & s_req_ready_i;

  assign s_addr_o = s_req_valid_o ? win_req.addr : '0;
  assign s_data_o = s_req_valid_o ? win_req.data : '0;
  assign s_sel_o  = s_req_valid_o ? win_req.sel  : '0;
  assign s_we_o   = s_req_valid_o & win_req.we;

  assign m0_req_ready_o = accept & (win_id == ARB_ID_M0);
  assign m1_req_ready_o = accept & (win_id == ARB_ID_M1);

  // Response demux follows the oldest outstanding ID.
  assign rsp_ready_sel  = (head_id == ARB_ID_M1) ? m1_rsp_ready_i : m0_rsp_ready_i;
  assign s_rsp_ready_o  = ~fifo_empty & rsp_ready_sel;
  assign m0_rsp_valid_o = s_rsp_valid_i & ~fifo_empty & (head_id == ARB_ID_M0);
  assign m1_rsp_valid_o = s_rsp_valid_i & ~fifo_empty & (head_id == ARB_ID_M1);
  assign m0_data_o      = m0_rsp_valid_o ? s_data_i : '0;
  assign m1_data_o      = m1_rsp_valid_o ? s_data_i : '0;
  assign pop            = s_rsp_valid_i & s_rsp_ready_o;

  // A presented but unaccepted request locks onto its master; accept or withdrawal returns to IDLE.
  always_comb begin
    state_d = ST_IDLE;
    if (s_req_valid_o && !s_req_ready_i) begin
      state_d = (win_id == ARB_ID_M1) ? ST_LOCK_M1 : ST_LOCK_M0;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!arb_en_q || !m1_req_valid_i || (accept && (win_id == ARB_ID_M1))) begin
      starve_d = '0;
    end else if (!(win_valid && (win_id == ARB_ID_M1)) && !force_m1) begin
      starve_d = starve_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      starve_q <= '0;
      arb_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      arb_en_q <= 1'b1;
    end
  end

  core_bus_arbiter_id_fifo #(
    .DEPTH(MAX_OUTST)
  ) u_id_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (accept),
    .push_id(win_id),
    .pop    (pop),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .head   (head_id)
  );

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_core_bus_arbiter;

  localparam int unsigned MAX_OUTST    = 2;
  localparam int unsigned STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_addr_i, m0_data_i, m1_addr_i, m1_data_i, s_data_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_req_valid_i, m0_rsp_ready_i;
  logic        m1_we_i, m1_req_valid_i, m1_rsp_ready_i;
  logic        s_req_ready_i, s_rsp_valid_i;
  logic        m0_req_ready_o, m0_rsp_valid_o, m1_req_ready_o, m1_rsp_valid_o;
  logic [31:0] m0_data_o, m1_data_o, s_addr_o, s_data_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_req_valid_o, s_rsp_ready_o;

  core_bus_arbiter #(.MAX_OUTST(MAX_OUTST), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_req_valid_i(m0_req_valid_i), .m0_req_ready_o(m0_req_ready_o), .m0_data_o(m0_data_o),
    .m0_rsp_valid_o(m0_rsp_valid_o), .m0_rsp_ready_i(m0_rsp_ready_i),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_req_valid_i(m1_req_valid_i), .m1_req_ready_o(m1_req_ready_o), .m1_data_o(m1_data_o),
    .m1_rsp_valid_o(m1_rsp_valid_o), .m1_rsp_ready_i(m1_rsp_ready_i),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_req_valid_o(s_req_valid_o), .s_req_ready_i(s_req_ready_i), .s_data_i(s_data_i),
    .s_rsp_valid_i(s_rsp_valid_i), .s_rsp_ready_o(s_rsp_ready_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: queue of outstanding owners, current lock owner (-1 = none), M1 wait count.
  int q_ids[$];
  int lock_own = -1;
  int wait_cnt = 0;
  bit en_m     = 1'b0;

  logic        obs_m0_rdy, obs_m1_rdy, obs_m0_rv, obs_m1_rv, obs_s_valid, obs_s_rsp_rdy;
  logic [31:0] obs_s_addr, obs_m0_data, obs_m1_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_ids.delete();
    lock_own = -1;
    wait_cnt = 0;
    en_m     = 1'b0;
  endtask

  // One clock: predict from the model, compare mid-cycle, then advance the model.
  task automatic cycle_check(input string tag);
    int          own, h;
    bit          own_v, full, s_v, acc, pop_e;
    logic [31:0] e_addr, e_wdata, e_m0d, e_m1d;
    logic [3:0]  e_sel;
    logic        e_we, e_rr, e_m0v, e_m1v;
    @(negedge clk);
    if (!rst_n) model_reset();
    own = 0;
    if (lock_own >= 0) own = lock_own;
    else if (m1_req_valid_i && (wait_cnt >= STARVE_LIMIT || !m0_req_valid_i)) own = 1;
    own_v  = en_m && ((own == 1) ? m1_req_valid_i : m0_req_valid_i);
    full   = (q_ids.size() >= MAX_OUTST);
    s_v    = own_v && !full;
    acc    = s_v && s_req_ready_i;
    e_addr = s_v ? ((own == 1) ? m1_addr_i : m0_addr_i) : 32'h0;
    e_wdata = s_v ? ((own == 1) ? m1_data_i : m0_data_i) : 32'h0;
    e_sel  = s_v ? ((own == 1) ? m1_sel_i : m0_sel_i) : 4'h0;
    e_we   = s_v && ((own == 1) ? m1_we_i : m0_we_i);
    e_rr = 1'b0; e_m0v = 1'b0; e_m1v = 1'b0;
    if (q_ids.size() > 0) begin
      h = q_ids[0];
      e_rr = (h == 1) ? m1_rsp_ready_i : m0_rsp_ready_i;
      if (h == 1) e_m1v = s_rsp_valid_i;
      else        e_m0v = s_rsp_valid_i;
    end
    e_m0d = e_m0v ? s_data_i : 32'h0;
    e_m1d = e_m1v ? s_data_i : 32'h0;
    pop_e = s_rsp_valid_i && e_rr;

    chk({tag, ".s_req_valid"}, 32'(s_req_valid_o), 32'(s_v));
    chk({tag, ".s_addr"}, s_addr_o, e_addr);
    chk({tag, ".s_data"}, s_data_o, e_wdata);
    chk({tag, ".s_sel"}, 32'(s_sel_o), 32'(e_sel));
    chk({tag, ".s_we"}, 32'(s_we_o), 32'(e_we));
    chk({tag, ".m0_req_ready"}, 32'(m0_req_ready_o), 32'(acc && own == 0));
    chk({tag, ".m1_req_ready"}, 32'(m1_req_ready_o), 32'(acc && own == 1));
    chk({tag, ".s_rsp_ready"}, 32'(s_rsp_ready_o), 32'(e_rr));
    chk({tag, ".m0_rsp_valid"}, 32'(m0_rsp_valid_o), 32'(e_m0v));
    chk({tag, ".m1_rsp_valid"}, 32'(m1_rsp_valid_o), 32'(e_m1v));
    chk({tag, ".m0_data"}, m0_data_o, e_m0d);
    chk({tag, ".m1_data"}, m1_data_o, e_m1d);

    obs_m0_rdy = m0_req_ready_o;  obs_m1_rdy = m1_req_ready_o;
    obs_m0_rv  = m0_rsp_valid_o;  obs_m1_rv  = m1_rsp_valid_o;
    obs_s_valid = s_req_valid_o;  obs_s_rsp_rdy = s_rsp_ready_o;
    obs_s_addr = s_addr_o; obs_m0_data = m0_data_o; obs_m1_data = m1_data_o;

    if (rst_n) begin
      if (!en_m) en_m = 1'b1;
      else begin
        if (pop_e) void'(q_ids.pop_front());
        if (acc) q_ids.push_back(own);
        lock_own = (s_v && !s_req_ready_i) ? own : -1;
        if (!m1_req_valid_i || (acc && own == 1)) wait_cnt = 0;
        else if (!(own_v && own == 1) && wait_cnt < STARVE_LIMIT) wait_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    m0_req_valid_i = 1'b0; m1_req_valid_i = 1'b0;
    s_rsp_valid_i = 1'b1; m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
    repeat (3) cycle_check("drain");
    s_rsp_valid_i = 1'b0;
  endtask

  initial begin
    int first;
    rst_n = 1'b0;
    m0_addr_i = 32'h1000; m0_data_i = 32'h0D0D_0000; m0_sel_i = 4'hF; m0_we_i = 1'b0;
    m1_addr_i = 32'h2000; m1_data_i = 32'h0E0E_0000; m1_sel_i = 4'h3; m1_we_i = 1'b1;
    m0_req_valid_i = 1'b1; m1_req_valid_i = 1'b1;
    m0_rsp_ready_i = 1'b1; m1_rsp_ready_i = 1'b1;
    s_req_ready_i = 1'b1; s_rsp_valid_i = 1'b1; s_data_i = 32'hDEAD_BEEF;

    // Reset with both masters requesting and a stray slave response
    repeat (2) cycle_check("t1_reset");
    chk("t1_rst_s_valid", 32'(obs_s_valid), 32'd0);
    chk("t1_rst_m0_rdy", 32'(obs_m0_rdy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle_check("t1_release");
    chk("t1_release_m0_rsp_valid", 32'(obs_m0_rv), 32'd0);

    // Collision: M0 first, M1 next; responses routed in order
    s_rsp_valid_i = 1'b0;
    cycle_check("t2_collide");
    chk("t2_m0_rdy", 32'(obs_m0_rdy), 32'd1);
    chk("t2_m1_rdy_blocked", 32'(obs_m1_rdy), 32'd0);
    m0_req_valid_i = 1'b0;
    cycle_check("t2_m1");
    chk("t2_m1_rdy", 32'(obs_m1_rdy), 32'd1);
    chk("t2_m1_addr", obs_s_addr, 32'h2000);
    m1_req_valid_i = 1'b0;
    s_rsp_valid_i = 1'b1; s_data_i = 32'hA5A5_0000;
    cycle_check("t2_rsp0");
    chk("t2_rsp0_m0_data", obs_m0_data, 32'hA5A5_0000);
    chk("t2_rsp0_m1_valid", 32'(obs_m1_rv), 32'd0);
    s_data_i = 32'h0000_5A5A;
    cycle_check("t2_rsp1");
    chk("t2_rsp1_m1_data", obs_m1_data, 32'h0000_5A5A);
    s_rsp_valid_i = 1'b0;

    // Lock: M1 held through slave stall even after M0 arrives
    m1_addr_i = 32'h3000; m1_req_valid_i = 1'b1; s_req_ready_i = 1'b0;
    cycle_check("t3_c1");
    m0_addr_i = 32'h1004; m0_req_valid_i = 1'b1;
    cycle_check("t3_c2");
    chk("t3_lock_addr", obs_s_addr, 32'h3000);
    cycle_check("t3_c3");
    chk("t3_lock_addr_c3", obs_s_addr, 32'h3000);
    s_req_ready_i = 1'b1;
    cycle_check("t3_c4");
    chk("t3_m1_accept", 32'(obs_m1_rdy), 32'd1);
    chk("t3_m0_wait", 32'(obs_m0_rdy), 32'd0);
    m1_req_valid_i = 1'b0;
    cycle_check("t3_c5");
    chk("t3_m0_served", 32'(obs_m0_rdy), 32'd1);
    drain();

    // Starvation: M1 forced through on the fifth cycle
    m0_req_valid_i = 1'b1; m1_req_valid_i = 1'b1; s_req_ready_i = 1'b1;
    s_rsp_valid_i = 1'b1; s_data_i = 32'h1234_5678;
    first = 0;
    for (int i = 1; i <= 6; i++) begin
      cycle_check("t4_starve");
      if (obs_m1_rdy === 1'b1 && first == 0) first = i;
    end
    chk("t4_m1_grant_cycle", 32'(first), 32'd5);
    drain();

    // Full FIFO: third request held until a response pops an entry
    s_rsp_valid_i = 1'b0; m1_req_valid_i = 1'b1;
    cycle_check("t5_c1");
    m1_req_valid_i = 1'b0; m0_req_valid_i = 1'b1;
    cycle_check("t5_c2");
    cycle_check("t5_c3");
    chk("t5_full_s_valid", 32'(obs_s_valid), 32'd0);
    s_rsp_valid_i = 1'b1; s_data_i = 32'h0000_0011;
    cycle_check("t5_c4");
    chk("t5_pop_m1_first", 32'(obs_m1_rv), 32'd1);
    chk("t5_no_push_on_pop", 32'(obs_s_valid), 32'd0);
    s_rsp_valid_i = 1'b0;
    cycle_check("t5_c5");
    chk("t5_third_accept", 32'(obs_m0_rdy), 32'd1);
    m0_req_valid_i = 1'b0; s_rsp_valid_i = 1'b1;
    cycle_check("t5_c6");
    chk("t5_order_m0", 32'(obs_m0_rv), 32'd1);
    drain();

    // Backpressure: head belongs to M1, M1 not ready
    m1_req_valid_i = 1'b1; s_rsp_valid_i = 1'b0;
    cycle_check("t6_c1");
    m1_req_valid_i = 1'b0; s_rsp_valid_i = 1'b1; m1_rsp_ready_i = 1'b0; m0_rsp_ready_i = 1'b1;
    repeat (2) begin
      cycle_check("t6_hold");
      chk("t6_s_rsp_ready", 32'(obs_s_rsp_rdy), 32'd0);
      chk("t6_m0_rsp_valid", 32'(obs_m0_rv), 32'd0);
      chk("t6_m1_rsp_valid", 32'(obs_m1_rv), 32'd1);
    end
    m1_rsp_ready_i = 1'b1;
    cycle_check("t6_pop");
    cycle_check("t6_empty");
    chk("t6_empty_rsp_ready", 32'(obs_s_rsp_rdy), 32'd0);
    chk("t6_empty_m1_valid", 32'(obs_m1_rv), 32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      m0_req_valid_i = ($urandom_range(0, 3) != 0);
      m1_req_valid_i = ($urandom_range(0, 2) != 0);
      m0_addr_i = $urandom; m0_data_i = $urandom; m0_sel_i = 4'($urandom); m0_we_i = 1'($urandom);
      m1_addr_i = $urandom; m1_data_i = $urandom; m1_sel_i = 4'($urandom); m1_we_i = 1'($urandom);
      s_req_ready_i  = ($urandom_range(0, 3) != 0);
      s_rsp_valid_i  = 1'($urandom);
      s_data_i       = $urandom;
      m0_rsp_ready_i = ($urandom_range(0, 3) != 0);
      m1_rsp_ready_i = ($urandom_range(0, 3) != 0);
      cycle_check("rand");
    end

    // Reset with requests outstanding; late responses must be dropped
    drain();
    m0_req_valid_i = 1'b1; s_req_ready_i = 1'b1; s_rsp_valid_i = 1'b0;
    repeat (2) cycle_check("t7_fill");
    m0_req_valid_i = 1'b0;
    rst_n = 1'b0;
    cycle_check("t7_reset");
    rst_n = 1'b1; s_rsp_valid_i = 1'b1;
    cycle_check("t7_late0");
    chk("t7_late0_m0_valid", 32'(obs_m0_rv), 32'd0);
    cycle_check("t7_late1");
    chk("t7_late1_rsp_ready", 32'(obs_s_rsp_rdy), 32'd0);
    chk("t7_late1_m0_valid", 32'(obs_m0_rv), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
